// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between the control unit, instruction memory and pc_sequencer.
interface pc_sequencer_if;
    logic [1:0]  PCSel;
    logic [31:0] Immd32;
    logic [25:0] JTarget;
    logic        ImemReady;
    logic        Resume;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic        FetchReq;
    logic        InsValid;
    logic        Halted;
    logic        FetchTimeout;
    logic [31:0] RetireCnt;

    modport master (
        output PCSel, Immd32, JTarget, ImemReady, Resume,
        input  PC, PC4, FetchReq, InsValid, Halted, FetchTimeout, RetireCnt
    );

    modport slave (
        input  PCSel, Immd32, JTarget, ImemReady, Resume,
        output PC, PC4, FetchReq, InsValid, Halted, FetchTimeout, RetireCnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/HALTED FSM with branch/jump select, stall timeout
// and an optional retire counter enabled by the PC_RETIRE_CNT_EN macro.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STALL_LIMIT = 16
) (
    input logic            CLK,
    input logic            RST,
    pc_sequencer_if.slave  bus
);
    typedef enum logic {RUN, HALTED} state_t;

    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt, pc4;
    logic [SW-1:0] stall_cnt, stall_nxt;
    logic          timeout, timeout_nxt;
    logic          fetch_req, ins_valid, halted;

    assign pc4 = pc + 32'd4;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            pc        <= RESET_PC;
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            stall_cnt <= stall_nxt;
            timeout   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        stall_nxt   = stall_cnt;
        timeout_nxt = timeout;
        fetch_req   = 1'b0;
        ins_valid   = 1'b0;
        halted      = 1'b0;
        case (state)
            RUN: begin
                fetch_req = 1'b1;
                if (bus.ImemReady) begin
                    ins_valid = 1'b1;
                    stall_nxt = '0;
                    case (bus.PCSel)
                        2'b00:   pc_nxt = pc4;
                        2'b01:   pc_nxt = pc4 + (bus.Immd32 << 2);
                        2'b10:   pc_nxt = {pc4[31:28], bus.JTarget, 2'b00};
                        default: state_nxt = HALTED;  // PC stays on the HALT word
                    endcase
                end else if (stall_cnt == STALL_LAST) begin
                    // this stall cycle is the STALL_LIMIT-th in a row
                    stall_nxt   = '0;
                    timeout_nxt = 1'b1;
                    state_nxt   = HALTED;
                end else begin
                    stall_nxt = stall_cnt + 1'b1;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (bus.Resume) begin
                    pc_nxt    = pc4;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign bus.PC           = pc;
    assign bus.PC4          = pc4;
    assign bus.FetchReq     = fetch_req;
    assign bus.InsValid     = ins_valid;
    assign bus.Halted       = halted;
    assign bus.FetchTimeout = timeout;

`ifdef PC_RETIRE_CNT_EN
    logic [31:0] retire_cnt;

    always_ff @(posedge CLK) begin
        if (RST)            retire_cnt <= '0;
        else if (ins_valid) retire_cnt <= retire_cnt + 32'd1;
    end

    assign bus.RetireCnt = retire_cnt;
`else
    assign bus.RetireCnt = '0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table, corner sequences and random
// traffic, all checked against a transaction-level model of the fetch rules.
module tb_pc_sequencer;
    localparam int LIMIT = 16;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    pc_sequencer_if bus();

    pc_sequencer #(.RESET_PC(RPC), .STALL_LIMIT(LIMIT)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model state
    bit          m_init = 0;
    logic [31:0] m_pc;
    bit          m_halted;
    int          m_stall;
    bit          m_to;
    logic [31:0] m_ret;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    task automatic step(input logic rst, input logic [1:0] sel, input logic [31:0] imm,
                        input logic [25:0] jt, input logic rdy, input logic res);
        logic [31:0] nxt4;
        RST           = rst;
        bus.PCSel     = sel;
        bus.Immd32    = imm;
        bus.JTarget   = jt;
        bus.ImemReady = rdy;
        bus.Resume    = res;
        #3;
        if (m_init) begin
            check("pc",        bus.PC,           m_pc);
            check("pc4",       bus.PC4,          m_pc + 32'd4);
            check("fetch_req", 32'(bus.FetchReq), 32'(!m_halted));
            check("ins_valid", 32'(bus.InsValid), 32'(!m_halted && rdy));
            check("halted",    32'(bus.Halted),   32'(m_halted));
            check("timeout",   32'(bus.FetchTimeout), 32'(m_to));
            check("retire",    bus.RetireCnt,     m_ret);
        end
        @(posedge CLK);
        cyc++;
        nxt4 = m_pc + 32'd4;
        if (rst) begin
            m_init = 1; m_pc = RPC; m_halted = 0; m_stall = 0; m_to = 0; m_ret = 0;
        end else if (m_halted) begin
            if (res) begin m_pc = nxt4; m_halted = 0; end
        end else if (rdy) begin
`ifdef PC_RETIRE_CNT_EN
            m_ret = m_ret + 32'd1;
`endif
            m_stall = 0;
            if (sel == 2'd0)      m_pc = nxt4;
            else if (sel == 2'd1) m_pc = nxt4 + imm * 32'd4;
            else if (sel == 2'd2) m_pc = (nxt4 & 32'hF000_0000) | ({6'd0, jt} * 32'd4);
            else                  m_halted = 1;
        end else begin
            m_stall++;
            if (m_stall == LIMIT) begin m_to = 1; m_halted = 1; m_stall = 0; end
        end
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  sel;
        logic [31:0] imm;
        logic [25:0] jt;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{1'b1, 2'd0, 32'h0,          26'h0,  32'h0000_0000};
        vt[1]  = '{1'b0, 2'd0, 32'h0,          26'h0,  32'h0000_0004};
        vt[2]  = '{1'b0, 2'd0, 32'h0,          26'h0,  32'h0000_0008};
        vt[3]  = '{1'b0, 2'd0, 32'h0,          26'h0,  32'h0000_000C};
        vt[4]  = '{1'b0, 2'd0, 32'h0,          26'h0,  32'h0000_0010};
        vt[5]  = '{1'b0, 2'd1, 32'hFFFF_FFFE,  26'h0,  32'h0000_000C};
        vt[6]  = '{1'b0, 2'd1, 32'h23FF_FFFC,  26'h0,  32'h9000_0000};
        vt[7]  = '{1'b0, 2'd2, 32'h0,          26'h10, 32'h9000_0040};
        vt[8]  = '{1'b0, 2'd2, 32'h0,          26'h2,  32'h9000_0008};
        vt[9]  = '{1'b0, 2'd1, 32'h1BFF_FFFC,  26'h0,  32'hFFFF_FFFC};
        vt[10] = '{1'b0, 2'd0, 32'h0,          26'h0,  32'h0000_0000};

        // directed table: sequential fetch, branch, jump, wrap
        for (int i = 0; i < 11; i++) begin
            step(vt[i].rst, vt[i].sel, vt[i].imm, vt[i].jt, 1'b1, 1'b0);
            check($sformatf("table_pc[%0d]", i), bus.PC, vt[i].exp_pc);
        end

        // sequential fetch retire count
        step(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
`ifdef PC_RETIRE_CNT_EN
        check("seq_retire3", bus.RetireCnt, 32'd3);
`else
        check("seq_retire0", bus.RetireCnt, 32'd0);
`endif

        // stall at PC=8 with RelJmp selected
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 2'd1, $urandom, 0, 0, 0);
            check("stall_pc", bus.PC, 32'h8);
        end

        // jump to 0x20, HALT there, sit halted 10 cycles, then resume
        step(0, 2'd2, 0, 26'h8, 1, 0);
        check("jump_20", bus.PC, 32'h20);
        step(0, 2'd3, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 2'($urandom), $urandom, 26'($urandom), 1'($urandom), 0);
            check("halt_pc", bus.PC, 32'h20);
            check("halt_flag", 32'(bus.Halted), 32'd1);
            check("halt_fetch", 32'(bus.FetchReq), 32'd0);
        end
        step(0, 0, 0, 0, 0, 1);
        check("resume_pc", bus.PC, 32'h24);
        check("resume_run", 32'(bus.Halted), 32'd0);

        // Resume in RUN is ignored
        step(0, 0, 0, 0, 0, 1);
        check("resume_in_run", bus.PC, 32'h24);

        // fresh timeout: LIMIT consecutive stalls
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < LIMIT; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (i == LIMIT - 2) check("pre_timeout", 32'(bus.FetchTimeout), 32'd0);
        end
        check("timeout_set", 32'(bus.FetchTimeout), 32'd1);
        check("timeout_halt", 32'(bus.Halted), 32'd1);
        step(0, 0, 0, 0, 0, 1);
        check("timeout_resume_pc", bus.PC, 32'h2C);
        check("timeout_sticky", 32'(bus.FetchTimeout), 32'd1);
        check("timeout_run", 32'(bus.Halted), 32'd0);

        // reset while halted with Resume asserted
        step(0, 2'd3, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1);
        check("rst_halt_pc", bus.PC, RPC);
        check("rst_halt_run", 32'(bus.Halted), 32'd0);
        check("rst_halt_to", 32'(bus.FetchTimeout), 32'd0);
        check("rst_halt_ret", bus.RetireCnt, 32'd0);

        // reset mid-stall restarts the stall window
        for (int i = 0; i < LIMIT - 1; i++) step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < LIMIT - 1; i++) step(0, 0, 0, 0, 0, 0);
        check("rst_mid_stall", 32'(bus.Halted), 32'd0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0, 2'($urandom), $urandom, 26'($urandom),
                 $urandom_range(0, 3) != 0 && $urandom_range(0, 40) != 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; the ports are named CLK and RST.
REQ-002 Parameters SHALL be:
- RESET_PC, default 32'h0000_0000, PC value loaded on reset.
- STALL_LIMIT, default 16, number of consecutive not-ready fetch cycles that raises a fetch timeout.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1: clock.
- RST, in, 1: synchronous active-high reset.
- PCSel, in, 2: next-PC select from control unit, encoded 00 NextIns, 01 RelJmp, 10 AbsJmp, 11 HALT.
- Immd32, in, 32: sign-extended branch word offset.
- JTarget, in, 26: jump word target.
- ImemReady, in, 1: instruction memory holds a valid word for the current PC.
- Resume, in, 1: restart request while halted.
- PC, out, 32: current fetch address.
- PC4, out, 32: PC+4.
- FetchReq, out, 1: fetch request to instruction memory.
- InsValid, out, 1: the current instruction commits this cycle.
- Halted, out, 1: sequencer is in HALTED.
- FetchTimeout, out, 1: sticky stall-limit flag.
- RetireCnt, out, 32: committed-instruction count.

Function
REQ-004 The FSM SHALL have states RUN and HALTED.
REQ-005 RUN behaviour:
- FetchReq=1, Halted=0.
- InsValid = ImemReady, combinationally.
- PCSel SHALL be sampled only when InsValid=1.
- PC SHALL be held on cycles where InsValid=0.
REQ-006 Next PC on an InsValid cycle:
- NextIns: PC+4.
- RelJmp: PC+4+(Immd32<<2), modulo 2^32.
- AbsJmp: {PC4[31:28], JTarget, 2'b00}.
- PC SHALL update at the next CLK edge.
REQ-007 HALT on an InsValid cycle SHALL hold PC at the HALT instruction address and enter HALTED at the next edge.
REQ-008 HALTED behaviour:
- FetchReq=0, InsValid=0, Halted=1.
- ImemReady and PCSel SHALL be ignored.
REQ-009 Resume=1 in HALTED SHALL set PC to PC+4 and return to RUN at the next edge.
REQ-010 Resume SHALL be ignored in RUN.
REQ-011 PC4 SHALL always equal PC+4, combinationally, with wrap at 2^32.
REQ-012 The stall counter SHALL:
- increment each RUN cycle with ImemReady=0;
- clear on any InsValid cycle and on entering HALTED.
REQ-013 When the stall counter reaches STALL_LIMIT:
- FetchTimeout SHALL set (sticky) and the FSM SHALL enter HALTED at that edge.
- FetchTimeout SHALL clear only on RST, not on Resume.
REQ-014 Resume after a timeout SHALL advance PC by 4, the same as after HALT.
REQ-015 PC values SHALL always be word-aligned; PC[1:0] SHALL stay 00 when RESET_PC is aligned.

Reset
REQ-016 RST=1 at a CLK edge SHALL force state RUN and set:
- PC=RESET_PC;
- stall counter 0, FetchTimeout 0, RetireCnt 0.
REQ-017 RST SHALL take priority over Resume, HALT and timeout in the same cycle, including reset mid-stall or while halted.
REQ-018 The first cycle after reset SHALL give FetchReq=1, Halted=0, PC=RESET_PC.

Configuration
REQ-019 The macro PC_RETIRE_CNT_EN SHALL control the retire counter:
- Defined: RetireCnt increments by 1 on every InsValid cycle, including the HALT instruction, and wraps from 32'hFFFF_FFFF to 0.
- Undefined: RetireCnt is tied to 0 and no counter register exists.

Verification
REQ-020 Sequential fetch: RST then ImemReady=1, PCSel=00 for 3 cycles -> PC sequence 0,4,8,12; RetireCnt=3 (with PC_RETIRE_CNT_EN).
REQ-021 Branch and jump:
- PC=32'h10, RelJmp, Immd32=32'hFFFF_FFFE -> PC=32'h0C.
- PC=32'h9000_0000, AbsJmp, JTarget=26'h10 -> PC=32'h9000_0040.
REQ-022 Stall: ImemReady=0 for 5 cycles at PC=8 with PCSel=01 -> PC stays 8, InsValid=0, RetireCnt unchanged.
REQ-023 Halt/resume:
- HALT at PC=32'h20 -> Halted=1, FetchReq=0, PC=32'h20 for 10 cycles.
- Resume pulse -> PC=32'h24, RUN next cycle.
REQ-024 Timeout: ImemReady=0 for 16 cycles (STALL_LIMIT=16) -> FetchTimeout=1, Halted=1; Resume -> RUN with FetchTimeout still 1.
REQ-025 Reset while HALTED with Resume=1 in the same cycle -> RUN, PC=RESET_PC, FetchTimeout=0, RetireCnt=0.
